seq_mul_div: RTL
================

SEQ_MUL_DIV -- requirements
Module: seq_mul_div

Interface
REQ-001 clock  input  1  single clock; all state SHALL update on rising edge only.
REQ-002 clear  input  1  reset, synchronous, active-high; SHALL take effect only on a rising clock edge.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-005 a  input  32  multiplicand / dividend (driven from Y register); sampled with start.
REQ-006 b  input  32  multiplier / divisor (driven from BusMuxOut); sampled with start.
REQ-007 busy  output  1  high while an operation is in progress (state RUN).
REQ-008 done  output  1  one-cycle completion pulse (state DONE).
REQ-009 z_high  output  32  product[63:32] or remainder; feeds Z register high half.
REQ-010 z_low  output  32  product[31:0] or quotient; feeds Z register low half.
REQ-011 div_by_zero  output  1  set at completion of a divide with b = 0; held until next completion.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE + start=1 at edge E0: SHALL capture a, b, op into internal registers, clear the iteration counter, enter RUN; start=0 keeps IDLE.
REQ-014 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change while in RUN, regardless of a/b input activity.
REQ-015 RUN SHALL perform one iteration per edge, edges E1..E32 (32 iterations, 6-bit counter).
REQ-016 At E32 FSM SHALL enter DONE, load z_high/z_low/div_by_zero; done=1 and busy=0 for the following single cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge; z_high, z_low, div_by_zero SHALL hold until the next completion or clear.
REQ-018 Multiply SHALL use radix-2 Booth recoding on a 65-bit accumulator {A[31:0], Q[31:0], q-1}, arithmetic right shift each iteration; result = full 64-bit two's-complement product of signed a × signed b.
REQ-019 Divide SHALL use 32-iteration restoring or non-restoring division on operand magnitudes, then sign correction: quotient truncated toward zero, negated iff a and b signs differ; remainder takes sign of a; |remainder| < |b|.
REQ-020 Divide result mapping: z_low = quotient, z_high = remainder.
REQ-021 Divide with b = 0 (detected at E0): FSM SHALL skip RUN, enter DONE at E1 with z_low = 0xFFFFFFFF, z_high = a, div_by_zero = 1.
REQ-022 Divide 0x80000000 / 0xFFFFFFFF SHALL yield z_low = 0x80000000, z_high = 0x00000000, div_by_zero = 0 (wrap, no flag).
REQ-023 Any non-zero-divisor completion SHALL set div_by_zero = 0.
REQ-024 Internal arithmetic SHALL use 33-bit widths where needed so 0x80000000 magnitude does not overflow.

Reset
REQ-025 clear=1 at an edge SHALL force IDLE, busy=0, done=0, z_high=0, z_low=0, div_by_zero=0, counter=0, captured operands=0.
REQ-026 clear SHALL take priority over start and over any in-progress iteration; an operation aborted by clear SHALL produce no done pulse.
REQ-027 After clear deasserts, a start in the first IDLE cycle SHALL be accepted normally.

Verification
REQ-028 op=0, a=7, b=0xFFFFFFFD (-3), start at E0 -> busy E1..E32, done only in cycle after E32, z_high=0xFFFFFFFF, z_low=0xFFFFFFEB.
REQ-029 op=0, a=b=0x80000000 -> z_high=0x40000000, z_low=0x00000000; then a=0xFFFFFFFF, b=0xFFFFFFFF -> z_high=0, z_low=1.
REQ-030 op=1, a=17, b=0xFFFFFFFB (-5) -> z_low=0xFFFFFFFD, z_high=0x00000002; a=0xFFFFFFEF (-17), b=5 -> z_low=0xFFFFFFFD, z_high=0xFFFFFFFE.
REQ-031 op=1, a=100, b=0 -> done in cycle after E1, z_low=0xFFFFFFFF, z_high=0x00000064, div_by_zero=1; next normal divide clears flag.
REQ-032 op=1, a=0x80000000, b=0xFFFFFFFF -> z_low=0x80000000, z_high=0, div_by_zero=0.
REQ-033 Start multiply, assert clear at E10, toggle start during RUN -> outputs all 0 after E10, no done pulse; new start after clear completes with correct result 33 edges later.

Source files
------------

// File: rtl/seq_mul_div.sv
// Sequential 32x32 signed multiplier (radix-2 Booth) and signed divider (restoring).
// One iteration per clock; 32 iterations per operation, results held until the next completion.
module seq_mul_div (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_high,
    output logic [31:0] z_low,
    output logic        div_by_zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          op_q, op_q_d;
    logic          a_neg, a_neg_d;
    logic          b_neg, b_neg_d;
    logic          dbz_pend, dbz_pend_d;
    logic [W:0]    acc_hi, acc_hi_d;
    logic [W-1:0]  acc_lo, acc_lo_d;
    logic          q_m1, q_m1_d;
    logic [W:0]    m, m_d;
    logic [W-1:0]  z_high_d, z_low_d;
    logic          dbz_d;

    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    hi_step;
    logic [W-1:0]  lo_step;
    logic          qm1_step;
    logic [W:0]    booth_sum;
    logic [W:0]    shifted_rem;
    logic [W-1:0]  quot_mag, rem_mag;

    assign a_mag = a[W-1] ? (W'(0) - a) : a;
    assign b_mag = b[W-1] ? (W'(0) - b) : b;

    // One iteration: Booth add/sub + arithmetic shift, or restoring shift/subtract.
    always_comb begin
        booth_sum   = acc_hi;
        shifted_rem = {acc_hi[W-1:0], acc_lo[W-1]};
        hi_step     = acc_hi;
        lo_step     = acc_lo;
        qm1_step    = q_m1;
        if (!op_q) begin
            case ({acc_lo[0], q_m1})
                2'b01:   booth_sum = acc_hi + m;
                2'b10:   booth_sum = acc_hi - m;
                default: booth_sum = acc_hi;
            endcase
            hi_step  = {booth_sum[W], booth_sum[W:1]};
            lo_step  = {booth_sum[0], acc_lo[W-1:1]};
            qm1_step = acc_lo[0];
        end else begin
            if (shifted_rem >= m) begin
                hi_step = shifted_rem - m;
                lo_step = {acc_lo[W-2:0], 1'b1};
            end else begin
                hi_step = shifted_rem;
                lo_step = {acc_lo[W-2:0], 1'b0};
            end
        end
    end

    assign quot_mag = lo_step;
    assign rem_mag  = hi_step[W-1:0];

    // Next-state and next-register logic.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        op_q_d     = op_q;
        a_neg_d    = a_neg;
        b_neg_d    = b_neg;
        dbz_pend_d = dbz_pend;
        acc_hi_d   = acc_hi;
        acc_lo_d   = acc_lo;
        q_m1_d     = q_m1;
        m_d        = m;
        z_high_d   = z_high;
        z_low_d    = z_low;
        dbz_d      = div_by_zero;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    op_q_d   = op;
                    a_neg_d  = a[W-1];
                    b_neg_d  = b[W-1];
                    acc_hi_d = '0;
                    q_m1_d   = 1'b0;
                    if (op) begin
                        dbz_pend_d = (b == '0);
                        acc_lo_d   = (b == '0) ? a : a_mag;
                        m_d        = {1'b0, b_mag};
                    end else begin
                        dbz_pend_d = 1'b0;
                        acc_lo_d   = a;
                        m_d        = {b[W-1], b};
                    end
                end
            end
            RUN: begin
                if (dbz_pend) begin
                    // Zero divisor: no iterations, report the dividend as remainder.
                    state_d  = DONE;
                    z_low_d  = '1;
                    z_high_d = acc_lo;
                    dbz_d    = 1'b1;
                end else begin
                    acc_hi_d = hi_step;
                    acc_lo_d = lo_step;
                    q_m1_d   = qm1_step;
                    cnt_d    = cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        state_d = DONE;
                        dbz_d   = 1'b0;
                        if (!op_q) begin
                            z_high_d = hi_step[W-1:0];
                            z_low_d  = lo_step;
                        end else begin
                            z_low_d  = (a_neg ^ b_neg) ? (W'(0) - quot_mag) : quot_mag;
                            z_high_d = a_neg ? (W'(0) - rem_mag) : rem_mag;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            dbz_pend    <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            q_m1        <= 1'b0;
            m           <= '0;
            z_high      <= '0;
            z_low       <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            op_q        <= op_q_d;
            a_neg       <= a_neg_d;
            b_neg       <= b_neg_d;
            dbz_pend    <= dbz_pend_d;
            acc_hi      <= acc_hi_d;
            acc_lo      <= acc_lo_d;
            q_m1        <= q_m1_d;
            m           <= m_d;
            z_high      <= z_high_d;
            z_low       <= z_low_d;
            div_by_zero <= dbz_d;
            busy        <= (state_d == RUN);
            done        <= (state_d == DONE);
        end
    end

endmodule
